// File: rtl/ifm_pingpong_buffer_pkg.sv
// ifm_pingpong_buffer_pkg: shared types and helpers for the ping-pong
// feature-map buffer (bank ownership states, word-address composition).
package ifm_pingpong_buffer_pkg;

    // Ownership state of one bank.
    typedef enum logic [1:0] {
        BANK_FREE    = 2'd0,
        BANK_WRITING = 2'd1,
        BANK_FULL    = 2'd2,
        BANK_READING = 2'd3
    } bank_state_t;

    // Word address inside a lane RAM: slices are stacked, each one map in size.
    function automatic int unsigned ifm_word_addr(input int unsigned sel,
                                                  input int unsigned addr,
                                                  input int unsigned pix);
        return sel * pix + addr;
    endfunction

endpackage

// File: rtl/ifm_lane_ram.sv
// ifm_lane_ram: simple dual-port RAM, one write port and one registered
// read-first read port. The read register holds its value while re_i is low.
module ifm_lane_ram
    import ifm_pingpong_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 200,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Storage array; contents are not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Registered read; sampling the array before the write lands gives read-first.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)     rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ifm_pingpong_buffer.sv
// ifm_pingpong_buffer: two-bank feature-map buffer between a conv stage
// (producer, writes and reads back partial sums) and the next layer
// (consumer, drains a completed map). A bank-ownership FSM overlaps filling
// and draining. Define IFM_PINGPONG_ERR_EN to build the sticky protocol checker.
module ifm_pingpong_buffer
    import ifm_pingpong_buffer_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int NUMBER_OF_UNITS  = 11,
    parameter int IFM_SIZE         = 5,
    parameter int NUMBER_OF_SLICES = 8,
    parameter int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE*IFM_SIZE),
    parameter int SEL_BITS         = $clog2(NUMBER_OF_SLICES)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start_from_previous,
    output logic                                  end_to_previous,
    input  logic                                  ifm_enable_read_previous,
    input  logic                                  ifm_enable_write_previous,
    input  logic [ADDRESS_SIZE_IFM-1:0]           ifm_address_read_previous,
    input  logic [ADDRESS_SIZE_IFM-1:0]           ifm_address_write_previous,
    input  logic [SEL_BITS-1:0]                   ifm_sel_previous,
    input  logic [NUMBER_OF_UNITS*DATA_WIDTH-1:0] data_in_from_previous,
    output logic [NUMBER_OF_UNITS*DATA_WIDTH-1:0] data_out_for_previous,
    output logic                                  start_to_next,
    input  logic                                  end_from_next,
    input  logic                                  ifm_enable_read_current,
    input  logic [ADDRESS_SIZE_IFM-1:0]           ifm_address_read_current,
    input  logic [SEL_BITS-1:0]                   ifm_sel_current,
    output logic [NUMBER_OF_UNITS*DATA_WIDTH-1:0] data_out_for_next,
    output logic                                  protocol_error
);

    localparam int PIX   = IFM_SIZE * IFM_SIZE;
    localparam int DEPTH = NUMBER_OF_SLICES * PIX;
    localparam int WA_W  = $clog2(DEPTH);
    localparam int LW    = NUMBER_OF_UNITS * DATA_WIDTH;

    bank_state_t bank_q [2];
    bank_state_t bank_d [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        prod_wait_q, prod_wait_d;
    logic        end_prev_q, end_prev_d;
    logic        start_next_q, start_next_d;

    logic        prod_ok, cons_ok, fill_ok, rel_ok;
    logic [WA_W-1:0] prev_waddr, prev_raddr, cur_raddr;

    logic [1:0][NUMBER_OF_UNITS-1:0][DATA_WIDTH-1:0] rdata;

    // Read-side bookkeeping: which bank fed the last read and whether it was legal.
    logic          prev_vld_q, prev_ok_q, prev_bank_q;
    logic          cur_vld_q, cur_ok_q, cur_bank_q;
    logic [LW-1:0] prev_hold_q, cur_hold_q;
    logic [LW-1:0] prev_live, cur_live;

    assign prod_ok = (bank_q[wr_ptr_q] == BANK_WRITING);
    assign cons_ok = (bank_q[rd_ptr_q] == BANK_READING);
    assign fill_ok = start_from_previous && prod_ok;
    assign rel_ok  = end_from_next && cons_ok;

    assign prev_waddr = WA_W'(ifm_word_addr(32'(ifm_sel_previous), 32'(ifm_address_write_previous), PIX));
    assign prev_raddr = WA_W'(ifm_word_addr(32'(ifm_sel_previous), 32'(ifm_address_read_previous), PIX));
    assign cur_raddr  = WA_W'(ifm_word_addr(32'(ifm_sel_current), 32'(ifm_address_read_current), PIX));

    // Bank ownership next state: consumer release, then producer fill, then hand-off.
    always_comb begin
        bank_d       = bank_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        prod_wait_d  = prod_wait_q;
        end_prev_d   = 1'b0;
        start_next_d = 1'b0;
        if (rel_ok) begin
            bank_d[rd_ptr_q] = BANK_FREE;
            rd_ptr_d         = ~rd_ptr_q;
            if (prod_wait_q) begin
                // Stalled producer takes the bank just released.
                bank_d[rd_ptr_q] = BANK_WRITING;
                wr_ptr_d         = rd_ptr_q;
                prod_wait_d      = 1'b0;
                end_prev_d       = 1'b1;
            end
        end
        if (fill_ok) begin
            bank_d[wr_ptr_q] = BANK_FULL;
            if (bank_d[~wr_ptr_q] == BANK_FREE) begin
                bank_d[~wr_ptr_q] = BANK_WRITING;
                wr_ptr_d          = ~wr_ptr_q;
                end_prev_d        = 1'b1;
            end else begin
                prod_wait_d = 1'b1;
            end
        end
        if (bank_d[rd_ptr_d] == BANK_FULL &&
            bank_d[0] != BANK_READING && bank_d[1] != BANK_READING) begin
            bank_d[rd_ptr_d] = BANK_READING;
            start_next_d     = 1'b1;
        end
    end

    // Ownership registers and handshake pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_q[0]    <= BANK_WRITING;
            bank_q[1]    <= BANK_FREE;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            prod_wait_q  <= 1'b0;
            end_prev_q   <= 1'b0;
            start_next_q <= 1'b0;
        end else begin
            bank_q       <= bank_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            prod_wait_q  <= prod_wait_d;
            end_prev_q   <= end_prev_d;
            start_next_q <= start_next_d;
        end
    end

    assign end_to_previous = end_prev_q;
    assign start_to_next   = start_next_q;

    // A bank is never WRITING and READING at once, so its single read port
    // goes to whichever side owns it.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        localparam logic BK = 1'(b);
        logic            prod_here, cons_here, re;
        logic [WA_W-1:0] raddr;
        assign prod_here = prod_ok && (wr_ptr_q == BK);
        assign cons_here = cons_ok && (rd_ptr_q == BK);
        assign re        = prod_here ? ifm_enable_read_previous
                                     : (ifm_enable_read_current && cons_here);
        assign raddr     = prod_here ? prev_raddr : cur_raddr;
        for (genvar l = 0; l < NUMBER_OF_UNITS; l++) begin : g_lane
            ifm_lane_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_ram (
                .clk_i  (clk),
                .rst_i  (reset),
                .we_i   (ifm_enable_write_previous && prod_here),
                .waddr_i(prev_waddr),
                .wdata_i(data_in_from_previous[l*DATA_WIDTH +: DATA_WIDTH]),
                .re_i   (re),
                .raddr_i(raddr),
                .rdata_o(rdata[b][l])
            );
        end
    end

    // Track the source of each read so the output can be zeroed when illegal
    // and held independently of later traffic on the same bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_vld_q  <= 1'b0;
            prev_ok_q   <= 1'b0;
            prev_bank_q <= 1'b0;
            cur_vld_q   <= 1'b0;
            cur_ok_q    <= 1'b0;
            cur_bank_q  <= 1'b0;
            prev_hold_q <= '0;
            cur_hold_q  <= '0;
        end else begin
            prev_vld_q  <= ifm_enable_read_previous;
            cur_vld_q   <= ifm_enable_read_current;
            if (ifm_enable_read_previous) begin
                prev_ok_q   <= prod_ok;
                prev_bank_q <= wr_ptr_q;
            end
            if (ifm_enable_read_current) begin
                cur_ok_q   <= cons_ok;
                cur_bank_q <= rd_ptr_q;
            end
            prev_hold_q <= data_out_for_previous;
            cur_hold_q  <= data_out_for_next;
        end
    end

    assign prev_live = prev_ok_q ? rdata[prev_bank_q] : '0;
    assign cur_live  = cur_ok_q  ? rdata[cur_bank_q]  : '0;
    assign data_out_for_previous = prev_vld_q ? prev_live : prev_hold_q;
    assign data_out_for_next     = cur_vld_q  ? cur_live  : cur_hold_q;

`ifdef IFM_PINGPONG_ERR_EN
    logic err_q, err_d;

    assign err_d = err_q
                 | (ifm_enable_write_previous && !prod_ok)
                 | (ifm_enable_read_current && !cons_ok)
                 | (start_from_previous && !fill_ok)
                 | (end_from_next && !rel_ok);

    // Sticky protocol violation flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign protocol_error = err_q;
`else
    assign protocol_error = 1'b0;
`endif

endmodule

// File: tb/tb_ifm_pingpong_buffer.sv
// tb_ifm_pingpong_buffer: directed stimulus with a queue-based ownership
// model and an array memory model compared every cycle, plus literal checks.
module tb_ifm_pingpong_buffer;
    localparam int DW    = 32;
    localparam int NU    = 11;
    localparam int IFS   = 5;
    localparam int NS    = 8;
    localparam int PIX   = IFS * IFS;
    localparam int DEPTH = NS * PIX;
    localparam int AW    = $clog2(PIX);
    localparam int SB    = $clog2(NS);

    logic clk = 1'b0;
    logic reset;
    logic start_from_previous, end_to_previous;
    logic ifm_enable_read_previous, ifm_enable_write_previous;
    logic [AW-1:0] ifm_address_read_previous, ifm_address_write_previous;
    logic [SB-1:0] ifm_sel_previous;
    logic [NU*DW-1:0] data_in_from_previous, data_out_for_previous;
    logic start_to_next, end_from_next, ifm_enable_read_current;
    logic [AW-1:0] ifm_address_read_current;
    logic [SB-1:0] ifm_sel_current;
    logic [NU*DW-1:0] data_out_for_next;
    logic protocol_error;

    ifm_pingpong_buffer #(.DATA_WIDTH(DW), .NUMBER_OF_UNITS(NU), .IFM_SIZE(IFS),
                          .NUMBER_OF_SLICES(NS)) dut (
        .clk(clk), .reset(reset),
        .start_from_previous(start_from_previous), .end_to_previous(end_to_previous),
        .ifm_enable_read_previous(ifm_enable_read_previous),
        .ifm_enable_write_previous(ifm_enable_write_previous),
        .ifm_address_read_previous(ifm_address_read_previous),
        .ifm_address_write_previous(ifm_address_write_previous),
        .ifm_sel_previous(ifm_sel_previous),
        .data_in_from_previous(data_in_from_previous),
        .data_out_for_previous(data_out_for_previous),
        .start_to_next(start_to_next), .end_from_next(end_from_next),
        .ifm_enable_read_current(ifm_enable_read_current),
        .ifm_address_read_current(ifm_address_read_current),
        .ifm_sel_current(ifm_sel_current),
        .data_out_for_next(data_out_for_next),
        .protocol_error(protocol_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    // ---------------- model ----------------
    int pb, cb;                 // bank held by producer / consumer, -1 = none
    int fullq[$], freeq[$];
    logic [DW-1:0] mem [2][NU][DEPTH];
    bit            kn  [2][NU][DEPTH];
    logic [DW-1:0] m_prev [NU], m_next [NU];
    bit            k_prev [NU], k_next [NU];
    bit m_endp, m_startn, m_err;

    task automatic model_reset();
        pb = 0; cb = -1;
        fullq.delete(); freeq.delete(); freeq.push_back(1);
        m_endp = 0; m_startn = 0; m_err = 0;
        for (int l = 0; l < NU; l++) begin
            m_prev[l] = '0; m_next[l] = '0; k_prev[l] = 1; k_next[l] = 1;
        end
        for (int b = 0; b < 2; b++)
            for (int l = 0; l < NU; l++)
                for (int a = 0; a < DEPTH; a++) kn[b][l][a] = 0;
    endtask

    task automatic model_step();
        int wa, ra, ca;
        wa = int'(ifm_sel_previous) * PIX + int'(ifm_address_write_previous);
        ra = int'(ifm_sel_previous) * PIX + int'(ifm_address_read_previous);
        ca = int'(ifm_sel_current) * PIX + int'(ifm_address_read_current);
        for (int l = 0; l < NU; l++) begin
            if (ifm_enable_read_previous) begin
                if (pb >= 0) begin m_prev[l] = mem[pb][l][ra]; k_prev[l] = kn[pb][l][ra]; end
                else begin m_prev[l] = '0; k_prev[l] = 1; end
            end
            if (ifm_enable_read_current) begin
                if (cb >= 0) begin m_next[l] = mem[cb][l][ca]; k_next[l] = kn[cb][l][ca]; end
                else begin m_next[l] = '0; k_next[l] = 1; end
            end
        end
`ifdef IFM_PINGPONG_ERR_EN
        if ((ifm_enable_write_previous && pb < 0) || (ifm_enable_read_current && cb < 0) ||
            (start_from_previous && pb < 0) || (end_from_next && cb < 0)) m_err = 1;
`endif
        if (ifm_enable_write_previous && pb >= 0)
            for (int l = 0; l < NU; l++) begin
                mem[pb][l][wa] = data_in_from_previous[l*DW +: DW];
                kn[pb][l][wa]  = 1;
            end
        m_endp = 0; m_startn = 0;
        if (end_from_next && cb >= 0) begin freeq.push_back(cb); cb = -1; end
        if (start_from_previous && pb >= 0) begin fullq.push_back(pb); pb = -1; end
        if (pb < 0 && freeq.size() > 0) begin pb = freeq.pop_front(); m_endp = 1; end
        if (cb < 0 && fullq.size() > 0) begin cb = fullq.pop_front(); m_startn = 1; end
    endtask

    always @(posedge clk) begin
        if (reset) model_reset();
        else       model_step();
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!reset && chk_on) begin
            chk("end_to_previous", 32'(end_to_previous), 32'(m_endp));
            chk("start_to_next", 32'(start_to_next), 32'(m_startn));
            chk("protocol_error", 32'(protocol_error), 32'(m_err));
            for (int l = 0; l < NU; l++) begin
                if (k_prev[l]) chk($sformatf("prev_lane%0d", l), data_out_for_previous[l*DW +: DW], m_prev[l]);
                if (k_next[l]) chk($sformatf("next_lane%0d", l), data_out_for_next[l*DW +: DW], m_next[l]);
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [NU*DW-1:0] mk(input logic [31:0] base, input logic [31:0] l3);
        logic [NU*DW-1:0] d;
        for (int l = 0; l < NU; l++) d[l*DW +: DW] = base + 32'(l);
        d[3*DW +: DW] = l3;
        return d;
    endfunction

    task automatic step();
        @(posedge clk); #1;
        ifm_enable_write_previous = 0; ifm_enable_read_previous = 0;
        ifm_enable_read_current = 0; start_from_previous = 0; end_from_next = 0;
    endtask

    task automatic pwr(input int s, input int a, input logic [NU*DW-1:0] d);
        ifm_sel_previous = SB'(s); ifm_address_write_previous = AW'(a);
        data_in_from_previous = d; ifm_enable_write_previous = 1;
    endtask

    task automatic prd(input int s, input int a);
        ifm_sel_previous = SB'(s); ifm_address_read_previous = AW'(a);
        ifm_enable_read_previous = 1;
    endtask

    task automatic crd(input int s, input int a);
        ifm_sel_current = SB'(s); ifm_address_read_current = AW'(a);
        ifm_enable_read_current = 1;
    endtask

    task automatic lit_hs(input string nm, input logic e, input logic s);
        @(negedge clk);
        chk({nm, "_end"}, 32'(end_to_previous), 32'(e));
        chk({nm, "_start"}, 32'(start_to_next), 32'(s));
    endtask

    initial begin
        reset = 1;
        start_from_previous = 0; end_from_next = 0;
        ifm_enable_read_previous = 0; ifm_enable_write_previous = 0; ifm_enable_read_current = 0;
        ifm_address_read_previous = '0; ifm_address_write_previous = '0; ifm_sel_previous = '0;
        ifm_address_read_current = '0; ifm_sel_current = '0; data_in_from_previous = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_end", 32'(end_to_previous), 0);
        chk("rst_start", 32'(start_to_next), 0);
        chk("rst_dprev", 32'(|data_out_for_previous), 0);
        chk("rst_dnext", 32'(|data_out_for_next), 0);
        chk("rst_err", 32'(protocol_error), 0);
        @(posedge clk); #1 reset = 0; chk_on = 1;

        // Fill bank0, read back, read-first collision.
        pwr(2, 7, mk(32'h1000, 32'hAB)); step();
        pwr(7, 24, mk(32'h7000, 32'h77)); step();
        pwr(0, 0, mk(32'h100, 32'h11)); step();
        prd(2, 7); step();
        @(negedge clk); chk("rb_lane3", data_out_for_previous[3*DW +: DW], 32'hAB);
        pwr(0, 0, mk(32'h200, 32'h22)); prd(0, 0); step();
        @(negedge clk); chk("rfirst_old", data_out_for_previous[0 +: DW], 32'h100);
        step();
        @(negedge clk); chk("held_old", data_out_for_previous[0 +: DW], 32'h100);
        prd(0, 0); step();
        @(negedge clk); chk("rfirst_new", data_out_for_previous[0 +: DW], 32'h200);

        // Hand bank0 to consumer, bank1 to producer.
        start_from_previous = 1; step(); lit_hs("swap1", 1, 1);
        step(); lit_hs("swap1_idle", 0, 0);
        crd(2, 7); step();
        @(negedge clk); chk("cons_lane3", data_out_for_next[3*DW +: DW], 32'hAB);
        @(negedge clk); chk("prev_hold", data_out_for_previous[0 +: DW], 32'h200);
        pwr(2, 7, mk(32'h5000, 32'h55)); step();
        pwr(7, 24, mk(32'h9000, 32'h99)); step();
        crd(7, 24); step();
        @(negedge clk); chk("cons_maxaddr", data_out_for_next[0 +: DW], 32'h7000);

        // Producer finishes while consumer busy -> stall.
        start_from_previous = 1; step(); lit_hs("wait", 0, 0);
        pwr(2, 7, mk(32'hE000, 32'hEE)); step();
`ifdef IFM_PINGPONG_ERR_EN
        @(negedge clk); chk("err_set", 32'(protocol_error), 1);
`endif
        prd(2, 7); step();
        @(negedge clk); chk("wait_rd_zero", data_out_for_previous[3*DW +: DW], 32'h0);
        end_from_next = 1; step(); lit_hs("release", 1, 1);
        crd(2, 7); prd(2, 7); step();
        @(negedge clk);
        chk("b1_unchanged", data_out_for_next[3*DW +: DW], 32'h55);
        chk("b0_retained", data_out_for_previous[3*DW +: DW], 32'hAB);

        // Simultaneous release and fill.
        start_from_previous = 1; end_from_next = 1; step(); lit_hs("simul", 1, 1);
        crd(2, 7); step();
        @(negedge clk); chk("simul_cons", data_out_for_next[3*DW +: DW], 32'hAB);

        // Release with nothing full, then an illegal release.
        end_from_next = 1; step(); lit_hs("rel_empty", 0, 0);
        end_from_next = 1; step(); lit_hs("illegal_end", 0, 0);
        crd(2, 7); step();
        @(negedge clk); chk("cons_none_zero", data_out_for_next[3*DW +: DW], 32'h0);
        start_from_previous = 1; step(); lit_hs("swap2", 1, 1);
        crd(2, 7); step();
        @(negedge clk); chk("swap2_cons", data_out_for_next[3*DW +: DW], 32'h55);
`ifdef IFM_PINGPONG_ERR_EN
        chk("err_sticky", 32'(protocol_error), 1);
`endif

        // Reset in the middle of a handshake.
        @(negedge clk); start_from_previous = 1; reset = 1; step();
        @(negedge clk);
        chk("mrst_end", 32'(end_to_previous), 0);
        chk("mrst_start", 32'(start_to_next), 0);
        chk("mrst_dnext", 32'(|data_out_for_next), 0);
        chk("mrst_dprev", 32'(|data_out_for_previous), 0);
        chk("mrst_err", 32'(protocol_error), 0);
        @(posedge clk); #1 reset = 0;
        pwr(1, 3, mk(32'h3000, 32'h33)); step();
        prd(1, 3); step();
        @(negedge clk); chk("post_rst_rb", data_out_for_previous[3*DW +: DW], 32'h33);
        start_from_previous = 1; step(); lit_hs("post_rst_swap", 1, 1);
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifm_pingpong_buffer.md
Name: ifm_pingpong_buffer

Overview:
- Double-banked inter-layer feature-map buffer sitting directly downstream of a convolution block stage.
- Producer side: the conv stage writes partial sums per output depth slice, with one lane per parallel unit, and reads them back for accumulation.
- Consumer side: the next layer's conv/pool stage drains the completed feature map.
- A bank-ownership FSM overlaps producer filling and consumer draining, using start/end pulse handshakes.

Parameters:
- DATA_WIDTH, 32, word width per lane
- NUMBER_OF_UNITS, 11, parallel lanes (one RAM per lane per bank)
- IFM_SIZE, 5, stored map side (producer IFM_SIZE_NEXT)
- NUMBER_OF_SLICES, 8, depth slices per lane (NUMBER_OF_FILTERS/NUMBER_OF_UNITS)
- ADDRESS_SIZE_IFM, $clog2(IFM_SIZE*IFM_SIZE), pixel address width (derived)
- SEL_BITS, $clog2(NUMBER_OF_SLICES), slice-select width (derived)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start_from_previous  in  1  pulse: producer finished filling its bank
- end_to_previous  out  1  pulse: new bank granted to producer
- ifm_enable_read_previous  in  1  producer read-back enable
- ifm_enable_write_previous  in  1  producer write enable
- ifm_address_read_previous  in  ADDRESS_SIZE_IFM  read-back pixel address
- ifm_address_write_previous  in  ADDRESS_SIZE_IFM  write pixel address
- ifm_sel_previous  in  SEL_BITS  slice for producer read and write
- data_in_from_previous  in  NUMBER_OF_UNITS*DATA_WIDTH  write data, lane i at bits [i*DW +: DW]
- data_out_for_previous  out  NUMBER_OF_UNITS*DATA_WIDTH  read-back data
- start_to_next  out  1  pulse: full bank handed to consumer
- end_from_next  in  1  pulse: consumer finished with its bank
- ifm_enable_read_current  in  1  consumer read enable
- ifm_address_read_current  in  ADDRESS_SIZE_IFM  consumer pixel address
- ifm_sel_current  in  SEL_BITS  consumer slice
- data_out_for_next  out  NUMBER_OF_UNITS*DATA_WIDTH  consumer read data
- protocol_error  out  1  sticky error flag (see Optional Feature)

Behaviour:
- Storage: 2 banks × NUMBER_OF_UNITS lanes × NUMBER_OF_SLICES*IFM_SIZE² words. Word address = sel*IFM_SIZE² + addr.
- Bank state per bank: FREE, WRITING, FULL, READING. Registers wr_ptr, rd_ptr, prod_wait.
- Reset: bank0=WRITING, bank1=FREE, wr_ptr=0, rd_ptr=0, prod_wait=0. Outputs end_to_previous, start_to_next, data_out_* and protocol_error are all 0. RAM contents are undefined.
- Producer writes and read-backs target bank[wr_ptr] only, and only while that bank is WRITING. Otherwise writes are dropped and reads return 0.
- Consumer reads target bank[rd_ptr] only while it is READING. Otherwise reads return 0.
- Read latency: 1 cycle; data_out registered and held when enable is low.
- Same-cycle read and write to the same word returns old data (read-first).
- start_from_previous: bank[wr_ptr] goes WRITING→FULL.
  - If bank[~wr_ptr]==FREE: it becomes WRITING, wr_ptr toggles, and end_to_previous pulses the next cycle.
  - Else prod_wait=1.
- Consumer hand-off: when rd_ptr bank is FULL and no bank is READING, that bank becomes READING and start_to_next pulses for 1 cycle, one cycle after the FULL transition.
- end_from_next: bank[rd_ptr] goes READING→FREE and rd_ptr toggles.
  - If prod_wait: the freed bank becomes WRITING, wr_ptr updates to it, prod_wait clears, and end_to_previous pulses next cycle.
  - If the new rd_ptr bank is FULL: it becomes READING and start_to_next pulses next cycle.
- Simultaneous start_from_previous and end_from_next: both are applied in the same cycle, the consumer release first. The bank freed by the consumer can be granted to the producer immediately.
- Pulses that are illegal for the current state are ignored: start_from_previous with no WRITING bank, or end_from_next with no READING bank.
- Reset mid-operation returns everything to the reset state at once, and in-flight handshakes are discarded.

Optional Feature:
- Macro: IFM_PINGPONG_ERR_EN.
- Defined: protocol_error is set, sticky until reset, on any of:
  - a write while the producer holds no WRITING bank;
  - a consumer read with no READING bank;
  - an illegal start_from_previous or end_from_next pulse.
- Undefined: protocol_error is tied to 0 and no checking logic is generated.

Decomposition:
- Shared package: bank-state enum (FREE/WRITING/FULL/READING) and the address-composition helper function (sel*IFM_SIZE²+addr).
- Sub-module ifm_lane_ram: one simple dual-port RAM with registered, read-first read. It is instantiated 2×NUMBER_OF_UNITS times (producer read-back and consumer read are muxed per bank). The FSM stays in the top.

Test Plan:
- Reset → bank0 WRITING; end_to_previous=0, start_to_next=0, all data_out=0.
- Write lane3, sel=2, addr=7 with value 0x0000_00AB, then read back → data_out_for_previous lane3 = 0xAB one cycle after the enable.
- Pulse start_from_previous → start_to_next pulses 1 cycle later and end_to_previous pulses 1 cycle later (bank1 granted). Consumer reads sel=2, addr=7 → lane3 = 0xAB.
- Second start_from_previous while consumer still READING → prod_wait. Then end_from_next → end_to_previous pulses next cycle, start_to_next pulses for bank1 the same cycle, wr_ptr=0.
- start_from_previous and end_from_next in the same cycle, with the other bank READING → the freed bank is granted, and both end_to_previous and start_to_next pulse next cycle.
- With IFM_PINGPONG_ERR_EN: write during prod_wait → protocol_error=1 and stays 1 until reset; the RAM is unchanged.
